// File: rtl/decode_unit.sv
// RV32I decode stage: decodes the fetched instruction and registers it into the ID/EX boundary.
// Optional RV32M OP decoding is enabled with `define DECODE_RV32M_EN.
module decode_unit (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        stall,
  input  logic        flush,
  output logic        load_use_stall,
  output logic [4:0]  rf_rs1_addr,
  output logic [4:0]  rf_rs2_addr,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [3:0]  id_class,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [4:0]  id_rd,
  output logic [31:0] id_imm,
  output logic [2:0]  id_funct3,
  output logic        id_funct7b5,
  output logic        id_m_ext,
  output logic        id_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] CLS_OP      = 4'd0;
  localparam logic [3:0] CLS_OP_IMM  = 4'd1;
  localparam logic [3:0] CLS_LOAD    = 4'd2;
  localparam logic [3:0] CLS_STORE   = 4'd3;
  localparam logic [3:0] CLS_BRANCH  = 4'd4;
  localparam logic [3:0] CLS_JAL     = 4'd5;
  localparam logic [3:0] CLS_JALR    = 4'd6;
  localparam logic [3:0] CLS_LUI     = 4'd7;
  localparam logic [3:0] CLS_AUIPC   = 4'd8;
  localparam logic [3:0] CLS_MISC    = 4'd9;
  localparam logic [3:0] CLS_ILLEGAL = 4'd15;

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  logic [3:0]  dec_class;
  logic [31:0] dec_imm;
  logic        dec_rs1_used;
  logic        dec_rs2_used;
  logic        dec_rd_wr;
  logic        dec_m_ext;
  logic        dec_illegal;

  assign opcode      = if_inst[6:0];
  assign funct7      = if_inst[31:25];
  assign rf_rs1_addr = if_inst[19:15];
  assign rf_rs2_addr = if_inst[24:20];

  assign imm_i = {{20{if_inst[31]}}, if_inst[31:20]};
  assign imm_s = {{20{if_inst[31]}}, if_inst[31:25], if_inst[11:7]};
  assign imm_b = {{19{if_inst[31]}}, if_inst[31], if_inst[7], if_inst[30:25], if_inst[11:8], 1'b0};
  assign imm_u = {if_inst[31:12], 12'b0};
  assign imm_j = {{11{if_inst[31]}}, if_inst[31], if_inst[19:12], if_inst[20], if_inst[30:21], 1'b0};

  // Instruction class, operand usage and immediate selection
  always_comb begin
    dec_class    = CLS_ILLEGAL;
    dec_imm      = 32'd0;
    dec_rs1_used = 1'b0;
    dec_rs2_used = 1'b0;
    dec_rd_wr    = 1'b0;
    dec_m_ext    = 1'b0;
    dec_illegal  = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_class    = CLS_OP;
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
        dec_rd_wr    = 1'b1;
        if (funct7 == 7'h01) begin
`ifdef DECODE_RV32M_EN
          dec_m_ext   = 1'b1;
`else
          dec_illegal = 1'b1;
`endif
        end else if (funct7 != 7'h00 && funct7 != 7'h20) begin
          dec_illegal = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec_class    = CLS_OP_IMM;
        dec_imm      = imm_i;
        dec_rs1_used = 1'b1;
        dec_rd_wr    = 1'b1;
      end
      OPC_LOAD: begin
        dec_class    = CLS_LOAD;
        dec_imm      = imm_i;
        dec_rs1_used = 1'b1;
        dec_rd_wr    = 1'b1;
      end
      OPC_STORE: begin
        dec_class    = CLS_STORE;
        dec_imm      = imm_s;
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
      end
      OPC_BRANCH: begin
        dec_class    = CLS_BRANCH;
        dec_imm      = imm_b;
        dec_rs1_used = 1'b1;
        dec_rs2_used = 1'b1;
      end
      OPC_JAL: begin
        dec_class = CLS_JAL;
        dec_imm   = imm_j;
        dec_rd_wr = 1'b1;
      end
      OPC_JALR: begin
        dec_class    = CLS_JALR;
        dec_imm      = imm_i;
        dec_rs1_used = 1'b1;
        dec_rd_wr    = 1'b1;
      end
      OPC_LUI: begin
        dec_class = CLS_LUI;
        dec_imm   = imm_u;
        dec_rd_wr = 1'b1;
      end
      OPC_AUIPC: begin
        dec_class = CLS_AUIPC;
        dec_imm   = imm_u;
        dec_rd_wr = 1'b1;
      end
      OPC_FENCE, OPC_SYSTEM: dec_class = CLS_MISC;
      default: dec_illegal = 1'b1;
    endcase
    if (if_inst[1:0] != 2'b11) dec_illegal = 1'b1;
    // Illegal encodings carry no operands or immediate
    if (dec_illegal) begin
      dec_class    = CLS_ILLEGAL;
      dec_imm      = 32'd0;
      dec_rs1_used = 1'b0;
      dec_rs2_used = 1'b0;
      dec_rd_wr    = 1'b0;
      dec_m_ext    = 1'b0;
    end
  end

  // Dependent instruction behind a load must wait one cycle for the load data
  assign load_use_stall = if_valid & id_valid & (id_class == CLS_LOAD) & (id_rd != 5'd0) &
                          ((dec_rs1_used & (rf_rs1_addr == id_rd)) |
                           (dec_rs2_used & (rf_rs2_addr == id_rd)));

  // ID/EX register: flush > stall > hazard bubble > idle bubble > capture
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_class    <= 4'd0;
      id_rs1      <= 5'd0;
      id_rs2      <= 5'd0;
      id_rd       <= 5'd0;
      id_imm      <= 32'd0;
      id_funct3   <= 3'd0;
      id_funct7b5 <= 1'b0;
      id_m_ext    <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (flush || (!stall && (load_use_stall || !if_valid))) begin
      id_valid    <= 1'b0;
      id_pc       <= 32'd0;
      id_class    <= 4'd0;
      id_rs1      <= 5'd0;
      id_rs2      <= 5'd0;
      id_rd       <= 5'd0;
      id_imm      <= 32'd0;
      id_funct3   <= 3'd0;
      id_funct7b5 <= 1'b0;
      id_m_ext    <= 1'b0;
      id_illegal  <= 1'b0;
    end else if (!stall) begin
      id_valid    <= 1'b1;
      id_pc       <= if_pc;
      id_class    <= dec_class;
      id_rs1      <= dec_rs1_used ? rf_rs1_addr : 5'd0;
      id_rs2      <= dec_rs2_used ? rf_rs2_addr : 5'd0;
      id_rd       <= dec_rd_wr ? if_inst[11:7] : 5'd0;
      id_imm      <= dec_imm;
      id_funct3   <= if_inst[14:12];
      id_funct7b5 <= if_inst[30];
      id_m_ext    <= dec_m_ext;
      id_illegal  <= dec_illegal;
    end
  end

endmodule
